// File: rtl/register_file_bypass.sv
// register_file_bypass
//   Architectural register file for the pipelined MIPS core. It holds NREG
//   registers of DATA_W bits, with two combinational read ports and one
//   synchronous write port. Register 0 always reads as zero.
//
//   The block sits directly downstream of the hazard unit. When the hazard
//   unit sets a bit of rf_hazard_src, the matching read port returns this
//   cycle's write data (write-through) instead of the stored value.
//
//   Optional feature, macro RF_SCOREBOARD_EN:
//     When defined, a pending bit per register records an outstanding write,
//     for example a load in flight. busy_1 and busy_2 report the pending bit
//     of each read select, so decode can stall.
//     When undefined, pend_set and pend_sel are ignored and busy_1 and
//     busy_2 are tied to 0. The port list is the same in both builds.
//
// Ports
//   CLK            in   1       clock, rising edge
//   nRST           in   1       synchronous active-low reset
//   WEN            in   1       write enable (writeback stage)
//   wsel           in   SEL_W   write register select
//   wdat           in   DATA_W  write data
//   rsel_1/rsel_2  in   SEL_W   read selects
//   rf_hazard_src  in   2       bit0 bypasses port 1, bit1 bypasses port 2
//   rdat_1/rdat_2  out  DATA_W  read data, combinational
//   pend_set       in   1       mark pend_sel as pending
//   pend_sel       in   SEL_W   register being marked pending
//   busy_1/busy_2  out  1       read select has an outstanding write
module register_file_bypass #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int SEL_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              WEN,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [DATA_W-1:0] wdat,
  input  logic [SEL_W-1:0]  rsel_1,
  input  logic [SEL_W-1:0]  rsel_2,
  input  logic [1:0]        rf_hazard_src,
  output logic [DATA_W-1:0] rdat_1,
  output logic [DATA_W-1:0] rdat_2,
  input  logic              pend_set,
  input  logic [SEL_W-1:0]  pend_sel,
  output logic              busy_1,
  output logic              busy_2
);

  localparam logic [SEL_W:0] NREG_L = (SEL_W+1)'(NREG);

  logic [DATA_W-1:0] regs_r [NREG];

  // A select is usable only if it is nonzero and names a register that exists.
  logic wsel_ok_s, rsel_1_ok_s, rsel_2_ok_s, wr_ok_s;

  // Decode which selects address a real, writable register.
  always_comb begin
    wsel_ok_s   = (wsel   != {SEL_W{1'b0}}) && ({1'b0, wsel}   < NREG_L);
    rsel_1_ok_s = (rsel_1 != {SEL_W{1'b0}}) && ({1'b0, rsel_1} < NREG_L);
    rsel_2_ok_s = (rsel_2 != {SEL_W{1'b0}}) && ({1'b0, rsel_2} < NREG_L);
    wr_ok_s     = WEN && wsel_ok_s;
  end

  // Register array. Reset clears every entry. Writes to r0 or to
  // out-of-range selects are dropped, so r0 stays zero after reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[wsel] <= wdat;
    end
  end

  // Read ports with write-through bypass. The hazard unit alone decides
  // whether to bypass, so selects are not compared here. A bypass request
  // is honoured only when this cycle's write actually lands.
  always_comb begin
    rdat_1 = {DATA_W{1'b0}};
    rdat_2 = {DATA_W{1'b0}};
    if (!nRST) begin
      rdat_1 = {DATA_W{1'b0}};
      rdat_2 = {DATA_W{1'b0}};
    end else begin
      if (rf_hazard_src[0] && wr_ok_s) begin
        rdat_1 = wdat;
      end else if (rsel_1_ok_s) begin
        rdat_1 = regs_r[rsel_1];
      end else begin
        rdat_1 = {DATA_W{1'b0}};
      end
      if (rf_hazard_src[1] && wr_ok_s) begin
        rdat_2 = wdat;
      end else if (rsel_2_ok_s) begin
        rdat_2 = regs_r[rsel_2];
      end else begin
        rdat_2 = {DATA_W{1'b0}};
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] pend_r;
  logic            pend_sel_ok_s;

  // Pending select must name a real, nonzero register.
  always_comb begin
    pend_sel_ok_s = (pend_sel != {SEL_W{1'b0}}) && ({1'b0, pend_sel} < NREG_L);
  end

  // Pending bits. A landing write retires its register's pending bit. A
  // same-edge pend_set is applied afterwards, so a new producer that issues
  // on that edge keeps the register pending.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pend_r <= {NREG{1'b0}};
    end else begin
      if (wr_ok_s) begin
        pend_r[wsel] <= 1'b0;
      end
      if (pend_set && pend_sel_ok_s) begin
        pend_r[pend_sel] <= 1'b1;
      end
    end
  end

  // busy is hidden when the write lands this cycle, because the bypass
  // already supplies the value.
  always_comb begin
    busy_1 = 1'b0;
    busy_2 = 1'b0;
    if (nRST) begin
      busy_1 = rsel_1_ok_s && pend_r[rsel_1] && !(WEN && (wsel == rsel_1));
      busy_2 = rsel_2_ok_s && pend_r[rsel_2] && !(WEN && (wsel == rsel_2));
    end else begin
      busy_1 = 1'b0;
      busy_2 = 1'b0;
    end
  end
`else
  logic unused_pend_s;

  // Scoreboard inputs are not used in this build.
  always_comb begin
    unused_pend_s = pend_set ^ (^pend_sel);
    busy_1        = 1'b0;
    busy_2        = 1'b0;
  end
`endif

endmodule

// File: tb/tb_register_file_bypass.sv
// Testbench for register_file_bypass. Each cycle, the stimulus side pushes
// the expected outputs from a behavioural model. A separate monitor pops
// and compares them while the inputs are stable, before the next rising edge.
module tb_register_file_bypass;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int SEL_W  = 5;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              WEN;
  logic [SEL_W-1:0]  wsel;
  logic [DATA_W-1:0] wdat;
  logic [SEL_W-1:0]  rsel_1;
  logic [SEL_W-1:0]  rsel_2;
  logic [1:0]        rf_hazard_src;
  logic [DATA_W-1:0] rdat_1;
  logic [DATA_W-1:0] rdat_2;
  logic              pend_set;
  logic [SEL_W-1:0]  pend_sel;
  logic              busy_1;
  logic              busy_2;

  always #5 CLK = ~CLK;

  register_file_bypass #(.DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel_1(rsel_1), .rsel_2(rsel_2), .rf_hazard_src(rf_hazard_src),
    .rdat_1(rdat_1), .rdat_2(rdat_2), .pend_set(pend_set),
    .pend_sel(pend_sel), .busy_1(busy_1), .busy_2(busy_2)
  );

  typedef struct {
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic              b1;
    logic              b2;
  } exp_t;

  exp_t exp_q[$];

  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_pend [NREG];

  int checks = 0;
  int errors = 0;

  // Value a read port should show under the architectural rules.
  function automatic logic [DATA_W-1:0] model_read(input bit rst_n_v, input bit wen_v,
      input int ws, input logic [DATA_W-1:0] wd, input int s, input bit byp);
    if (!rst_n_v) return '0;
    if (byp && wen_v && ws != 0 && ws < NREG) return wd;
    if (s == 0 || s >= NREG) return '0;
    return m_regs[s];
  endfunction

  function automatic bit model_busy(input bit rst_n_v, input bit wen_v, input int ws, input int s);
`ifdef RF_SCOREBOARD_EN
    if (!rst_n_v || s == 0 || s >= NREG) return 1'b0;
    if (wen_v && ws == s) return 1'b0;
    return m_pend[s];
`else
    return 1'b0;
`endif
  endfunction

  // Drives one cycle. Expectations are computed from the pre-edge model,
  // and the model is then advanced past the coming rising edge.
  task automatic cycle(input bit rst_n_v, input bit wen_v, input int ws,
      input logic [DATA_W-1:0] wd, input int s1, input int s2,
      input logic [1:0] src, input bit ps, input int pss);
    exp_t e;
    @(negedge CLK);
    nRST = rst_n_v; WEN = wen_v; wsel = SEL_W'(ws); wdat = wd;
    rsel_1 = SEL_W'(s1); rsel_2 = SEL_W'(s2); rf_hazard_src = src;
    pend_set = ps; pend_sel = SEL_W'(pss);
    e.r1 = model_read(rst_n_v, wen_v, ws, wd, s1, src[0]);
    e.r2 = model_read(rst_n_v, wen_v, ws, wd, s2, src[1]);
    e.b1 = model_busy(rst_n_v, wen_v, ws, s1);
    e.b2 = model_busy(rst_n_v, wen_v, ws, s2);
    exp_q.push_back(e);
    if (!rst_n_v) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wen_v && ws != 0 && ws < NREG) begin
        m_regs[ws] = wd;
        m_pend[ws] = 1'b0;
      end
      if (ps && pss != 0 && pss < NREG) m_pend[pss] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compares the outputs shown during each driven cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdat_1", rdat_1, e.r1);
        chk("rdat_2", rdat_2, e.r2);
        chk("busy_1", {31'd0, busy_1}, {31'd0, e.b1});
        chk("busy_2", {31'd0, busy_2}, {31'd0, e.b2});
      end
    end
  end

  initial begin : stim
    int k;
    nRST = 1'b0; WEN = 1'b0; wsel = '0; wdat = '0; rsel_1 = '0; rsel_2 = '0;
    rf_hazard_src = 2'b00; pend_set = 1'b0; pend_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end

    // Reset, then read every register on both ports.
    cycle(1'b0, 1'b0, 0, 32'h0, 0, 0, 2'b00, 1'b0, 0);
    cycle(1'b0, 1'b0, 0, 32'h0, 0, 0, 2'b00, 1'b0, 0);
    for (int i = 0; i < NREG; i++) cycle(1'b1, 1'b0, 0, 32'h0, i, NREG-1-i, 2'b00, 1'b0, 0);

    // Basic write and read back. A write to r0 is discarded.
    cycle(1'b1, 1'b1, 5, 32'hDEADBEEF, 5, 0, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 32'h0, 5, 5, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b1, 0, 32'h00001234, 0, 0, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 32'h0, 5, 0, 2'b00, 1'b0, 0);

    // Write-through on both ports, then the stored value without bypass.
    cycle(1'b1, 1'b1, 7, 32'h11, 0, 0, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b1, 7, 32'h22, 7, 7, 2'b11, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 32'h0, 7, 7, 2'b00, 1'b0, 0);

    // Bypass is suppressed for r0 and when WEN is low.
    cycle(1'b1, 1'b1, 0, 32'hFFFF, 0, 5, 2'b01, 1'b0, 0);
    cycle(1'b1, 1'b0, 7, 32'h99, 0, 7, 2'b10, 1'b0, 0);

    // Scoreboard: set, hide on write, clear, set-wins on the same edge.
    cycle(1'b1, 1'b0, 0, 32'h0, 9, 9, 2'b00, 1'b1, 9);
    cycle(1'b1, 1'b0, 0, 32'h0, 9, 0, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b1, 9, 32'h909, 9, 9, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 32'h0, 9, 9, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 32'h0, 0, 0, 2'b00, 1'b1, 9);
    cycle(1'b1, 1'b1, 9, 32'hA0A, 0, 0, 2'b00, 1'b1, 9);
    cycle(1'b1, 1'b0, 0, 32'h0, 9, 0, 2'b00, 1'b1, 0);

    // Mid-run reset, with a write and a pending set on the reset edge.
    cycle(1'b1, 1'b1, 3, 32'h333, 0, 0, 2'b00, 1'b1, 4);
    cycle(1'b0, 1'b1, 3, 32'h444, 3, 4, 2'b11, 1'b1, 4);
    cycle(1'b1, 1'b0, 0, 32'h0, 3, 4, 2'b00, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 32'h0, 9, 5, 2'b00, 1'b0, 0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, NREG-1)), $urandom,
            int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)),
            2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            int'($urandom_range(0, NREG-1)));
    end

    // Wait, with a bound, for the monitor to drain the queue.
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
